// File: rtl/btn_conditioner.sv
// Push-button front-end: 2-flop synchroniser, per-channel debounce FSM, and a
// lowest-index-first strobe queue. Define AUTO_REPEAT_EN for auto-repeat while held.

module btn_channel #(
    parameter int DEBOUNCE_CYCLES = 500000,
`ifdef AUTO_REPEAT_EN
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
`endif
    parameter int CW              = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_ev
);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    sync_q;
    logic          sync, held, deb_done, rep_fire;

    assign sync     = sync_q[1];
    assign deb_done = (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            state  <= IDLE;
            cnt    <= '0;
            level  <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], raw};
            state  <= state_n;
            cnt    <= cnt_n;
            level  <= ~held;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (!sync) begin
                state_n = PRESS_WAIT;
                cnt_n   = '0;
            end
            PRESS_WAIT: begin
                if (sync)          state_n = IDLE;
                else if (deb_done) state_n = PRESSED;
                else               cnt_n   = cnt + CW'(1);
            end
            PRESSED: if (sync) begin
                state_n = RELEASE_WAIT;
                cnt_n   = '0;
            end
            RELEASE_WAIT: begin
                if (!sync)         state_n = PRESSED;
                else if (deb_done) state_n = IDLE;
                else               cnt_n   = cnt + CW'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    // Level is registered from the state so it lines up with the strobe.
    always_comb begin
        held     = (state == PRESSED) || (state == RELEASE_WAIT);
        press_ev = ((state == PRESS_WAIT) && !sync && deb_done) || rep_fire;
    end

`ifdef AUTO_REPEAT_EN
    logic [CW-1:0] rep_cnt;
    logic          rep_phase;

    assign rep_fire = (state == PRESSED) && !sync &&
                      (rep_cnt == (rep_phase ? CW'(REPEAT_PERIOD - 1) : CW'(REPEAT_DELAY - 1)));

    // Cleared whenever not in PRESSED, so every (re)entry restarts the delay.
    always_ff @(posedge clk) begin
        if (rst || state != PRESSED) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b1;
        end else begin
            rep_cnt   <= rep_cnt + CW'(1);
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

endmodule

module btn_conditioner #(
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic               press_valid,
    output logic               overflow
);

    localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_ALL = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int CW      = $clog2(MAX_ALL + 1);

    logic [NUM_BTN-1:0] ev, pending, grant;
    logic               found;

    genvar i;
    generate
        for (i = 0; i < NUM_BTN; i++) begin : g_ch
            btn_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`ifdef AUTO_REPEAT_EN
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_PERIOD  (REPEAT_PERIOD),
`endif
                .CW             (CW)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .raw     (btn_raw[i]),
                .level   (btn_level[i]),
                .press_ev(ev[i])
            );
        end
    endgenerate

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int j = 0; j < NUM_BTN; j++) begin
            if (pending[j] && !found) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // A new event on the channel being granted re-arms pending, so it is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= '0;
            btn_pulse   <= '1;
            press_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            pending     <= (pending & ~grant) | ev;
            btn_pulse   <= ~grant;
            press_valid <= |grant;
            if (|(ev & pending & ~grant)) overflow <= 1'b1;
        end
    end

endmodule
